// File: rtl/pc_gen_unit.sv
// Fetch-stage program counter with trap/redirect/stall priority, fetch handshake and flush pulse.
// Optional redirect alignment check is compiled in with `define PC_ALIGN_CHECK_EN.
module pc_gen_unit #(
    parameter int               XLEN         = 64,
    parameter int               INC          = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'('h100),
    parameter int               CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_req,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_req,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             flush,
    output logic [CNT_W-1:0] fetch_count,
    output logic             misalign_fault
);

    typedef enum logic {BOOT, RUN} state_e;

    localparam logic [XLEN-1:0]  INC_V = XLEN'(INC);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_e           state_q;
    logic [XLEN-1:0]  pc_q;
    logic             fetch_valid_q;
    logic             flush_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fire;

    assign fire        = fetch_valid_q & fetch_ready & ~stall;
    assign pc_plus_inc = pc_q + INC_V;

`ifdef PC_ALIGN_CHECK_EN
    // INC=4 needs word alignment, INC=2 only halfword alignment.
    localparam logic [1:0] ALIGN_MASK = (INC == 4) ? 2'b11 : 2'b01;
    logic fault_q;
    logic misaligned;
    assign misaligned     = |(redirect_target[1:0] & ALIGN_MASK);
    assign misalign_fault = fault_q;
`else
    assign misalign_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            cnt_q         <= '0;
`ifdef PC_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            flush_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
            if (state_q == BOOT) begin
                // Requests arriving before the first fetch are dropped on purpose.
                state_q       <= RUN;
                fetch_valid_q <= 1'b1;
            end else begin
                if (trap_req) begin
                    pc_q    <= TRAP_VECTOR;
                    flush_q <= 1'b1;
                end
`ifdef PC_ALIGN_CHECK_EN
                else if (redirect_req && misaligned) begin
                    pc_q    <= TRAP_VECTOR;
                    flush_q <= 1'b1;
                    fault_q <= 1'b1;
                end
`endif
                else if (redirect_req) begin
                    pc_q    <= redirect_target;
                    flush_q <= 1'b1;
                end else if (fire) begin
                    pc_q  <= pc_plus_inc;
                    cnt_q <= cnt_q + ONE_C;
                end
            end
        end
    end

    assign pc_out      = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign flush       = flush_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: vector table plus scoreboard queue, with hand-written reset/wrap sequences.
// Expectations follow PC_ALIGN_CHECK_EN when that macro is defined for the build.
module tb_pc_gen_unit;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [XLEN-1:0] MIS_PC    = 64'h100;
    localparam logic            MIS_FAULT = 1'b1;
`else
    localparam logic [XLEN-1:0] MIS_PC    = 64'h402;
    localparam logic            MIS_FAULT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             redirect_req;
    logic [XLEN-1:0]  redirect_target;
    logic             trap_req;
    logic             fetch_ready;
    logic             fetch_valid;
    logic [XLEN-1:0]  pc_out;
    logic [XLEN-1:0]  pc_plus_inc;
    logic             flush;
    logic [CNT_W-1:0] fetch_count;
    logic             misalign_fault;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .XLEN(XLEN), .INC(4), .RESET_VECTOR(64'h0), .TRAP_VECTOR(64'h100), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_req(redirect_req),
        .redirect_target(redirect_target), .trap_req(trap_req), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc_out(pc_out), .pc_plus_inc(pc_plus_inc), .flush(flush),
        .fetch_count(fetch_count), .misalign_fault(misalign_fault)
    );

    typedef struct {
        logic             stall;
        logic             redir;
        logic             trap;
        logic             ready;
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  pc;
        logic [CNT_W-1:0] cnt;
        logic             flush;
        logic             fault;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0]  pc;
        logic [CNT_W-1:0] cnt;
        logic             flush;
        logic             fault;
        logic             valid;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[19];

    function automatic vec_t mk(input logic st, input logic rd, input logic tr, input logic rdy,
                                input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] pc,
                                input logic [CNT_W-1:0] cnt, input logic fl, input logic flt);
        vec_t v;
        v.stall = st; v.redir = rd; v.trap = tr; v.ready = rdy; v.target = tgt;
        v.pc = pc; v.cnt = cnt; v.flush = fl; v.fault = flt;
        return v;
    endfunction

    task automatic check1(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected pending entry");
            return;
        end
        e = sb.pop_front();
        check1({e.tag, ".pc"},    pc_out,          e.pc);
        check1({e.tag, ".inc"},   pc_plus_inc,     e.pc + 64'd4);
        check1({e.tag, ".cnt"},   64'(fetch_count), 64'(e.cnt));
        check1({e.tag, ".flush"}, 64'(flush),      64'(e.flush));
        check1({e.tag, ".fault"}, 64'(misalign_fault), 64'(e.fault));
        check1({e.tag, ".valid"}, 64'(fetch_valid),    64'(e.valid));
    endtask

    // Drive on the falling edge, queue the expectation, compare just after the rising edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        stall = v.stall; redirect_req = v.redir; trap_req = v.trap;
        fetch_ready = v.ready; redirect_target = v.target;
        e.pc = v.pc; e.cnt = v.cnt; e.flush = v.flush; e.fault = v.fault; e.valid = 1'b1; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkResetState(input string tag);
        check1({tag, ".pc"},    pc_out,               64'h0);
        check1({tag, ".valid"}, 64'(fetch_valid),     64'h0);
        check1({tag, ".flush"}, 64'(flush),           64'h0);
        check1({tag, ".cnt"},   64'(fetch_count),     64'h0);
        check1({tag, ".fault"}, 64'(misalign_fault),  64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_req = 1'b0; trap_req = 1'b0;
        fetch_ready = 1'b0; redirect_target = '0;

        #12;
        checkResetState("rst0");
        repeat (2) @(posedge clk);
        #1;
        checkResetState("rst_hold");
        #1;
        reset = 1'b1;

        //                 st rd tr rdy target                   pc                      cnt fl flt
        tbl[0]  = mk(0, 1, 1, 1, 64'h400,                64'h0,                  0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 64'h0,                  64'h4,                  1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 64'h0,                  64'h8,                  2, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 64'h0,                  64'hC,                  3, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 64'h0,                  64'hC,                  3, 0, 0);
        tbl[5]  = mk(0, 1, 0, 1, 64'h20,                 64'h20,                 3, 1, 0);
        tbl[6]  = mk(1, 0, 0, 1, 64'h0,                  64'h20,                 3, 0, 0);
        tbl[7]  = mk(1, 0, 0, 1, 64'h0,                  64'h20,                 3, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 64'h0,                  64'h24,                 4, 0, 0);
        tbl[9]  = mk(1, 1, 1, 1, 64'h400,                64'h100,                4, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 64'h0,                  64'h100,                4, 0, 0);
        tbl[11] = mk(0, 1, 0, 1, 64'h402,                MIS_PC,                 4, 1, MIS_FAULT);
        tbl[12] = mk(0, 0, 0, 0, 64'h0,                  MIS_PC,                 4, 0, 0);
        tbl[13] = mk(0, 1, 0, 1, 64'h408,                64'h408,                4, 1, 0);
        tbl[14] = mk(0, 0, 0, 1, 64'h0,                  64'h40C,                5, 0, 0);
        tbl[15] = mk(0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 5, 1, 0);
        tbl[16] = mk(0, 0, 0, 1, 64'h0,                  64'h0,                  6, 0, 0);
        tbl[17] = mk(0, 0, 1, 0, 64'h0,                  64'h100,                6, 1, 0);
        tbl[18] = mk(1, 1, 0, 0, 64'h200,                64'h200,                6, 1, 0);

        for (int i = 0; i < 19; i++)
            applyStimulus(tbl[i], $sformatf("v%0d", i));

        // Ten sequential fetches carry the 4-bit counter from 6 through 15 back to 0.
        for (int i = 0; i < 10; i++)
            applyStimulus(mk(0, 0, 0, 1, 64'h0, 64'h200 + 64'(4 * (i + 1)), CNT_W'(7 + i), 0, 0),
                          $sformatf("wrap%0d", i));

        applyStimulus(mk(0, 1, 0, 0, 64'h80, 64'h80, 0, 1, 0), "to80");

        // Asynchronous reset between edges must clear everything without a clock.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkResetState("async");
        @(posedge clk);
        #1;
        checkResetState("async_hold");
        #1;
        reset = 1'b1;

        applyStimulus(mk(0, 0, 0, 1, 64'h0, 64'h0, 0, 0, 0), "reboot0");
        applyStimulus(mk(0, 0, 0, 1, 64'h0, 64'h4, 1, 0, 0), "reboot1");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
